// File: rtl/simmem_pkg.sv
// simmem_pkg: shared types and sizing helpers for the simulated-memory delay line.
// Optional statistics build switch: SIMMEM_DELAY_STATS_EN (see simmem_delay_line).
package simmem_pkg;

   // Default geometry of one lane; modules override these through their own parameters.
   localparam int DefaultDataWidth    = 64;
   localparam int DefaultCounterWidth = 8;
   localparam int DefaultDepth        = 8;

   // Pointer width carries one extra wrap bit so full and empty are distinguishable.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int DefaultPtrW = ptr_width(DefaultDepth);

   // One lane entry: message, release timestamp and sticky ripe flag.
   typedef struct packed {
      logic [DefaultDataWidth-1:0]    msg;
      logic [DefaultCounterWidth-1:0] rel_ts;
      logic                           ripe;
   } lane_entry_t;

endpackage

// File: rtl/simmem_delay_lane.sv
// simmem_delay_lane: one in-order FIFO lane whose head is released only once its
// timestamp has been reached. Statistics ports exist when SIMMEM_DELAY_STATS_EN is defined.
module simmem_delay_lane
   import simmem_pkg::*;
#(
   parameter int  DataWidth    = 64,
   parameter int  Depth        = 8,
   parameter int  CounterWidth = 8,
   localparam int PtrW         = ptr_width(Depth)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [CounterWidth-1:0] now_i,
   input  logic [CounterWidth-1:0] delay_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [DataWidth-1:0]    in_data_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [DataWidth-1:0]    out_data_o
`ifdef SIMMEM_DELAY_STATS_EN
   ,
   output logic [PtrW-1:0]         occupancy_o,
   output logic [31:0]             stall_cnt_o
`endif
);

   localparam int IdxW = PtrW - 1;

   typedef struct packed {
      logic [DataWidth-1:0]    msg;
      logic [CounterWidth-1:0] rel_ts;
   } payload_t;

   payload_t         mem_q [Depth];
   logic [Depth-1:0] ripe_q, ripe_d;
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic             ready_en_q;
   logic [IdxW-1:0]  wr_idx, rd_idx;
   logic [PtrW-1:0]  count;
   logic [Depth-1:0] occupied;
   logic             full, empty, push, pop;
   payload_t         head;

   assign wr_idx = wr_ptr_q[IdxW-1:0];
   assign rd_idx = rd_ptr_q[IdxW-1:0];
   assign full   = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) && (wr_idx == rd_idx);
   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign count  = wr_ptr_q - rd_ptr_q;
   assign head   = mem_q[rd_idx];

   // The head may release in the very cycle its timestamp matches, before the ripe bit lands.
   assign out_valid_o = !empty && (ripe_q[rd_idx] || (head.rel_ts == now_i));
   assign out_data_o  = empty ? '0 : head.msg;

   // Ready depends only on registered state, never on out_ready_i.
   assign in_ready_o = ready_en_q && !full;
   assign push       = in_valid_i && in_ready_o;
   assign pop        = out_valid_o && out_ready_i;

   // Next-state for the pointers and the sticky per-entry ripe bits.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ripe_d   = ripe_q;
      occupied = '0;
      for (int i = 0; i < Depth; i++) begin
         occupied[i] = {1'b0, IdxW'(i) - rd_idx} < count;
         if (occupied[i] && (mem_q[i].rel_ts == now_i)) ripe_d[i] = 1'b1;
      end
      if (pop) begin
         ripe_d[rd_idx] = 1'b0;
         rd_ptr_d       = rd_ptr_q + PtrW'(1);
      end
      if (push) begin
         ripe_d[wr_idx] = 1'b0;
         wr_ptr_d       = wr_ptr_q + PtrW'(1);
      end
   end

   // Control state: pointers, ripe bits, and the ready enable that rises one edge after reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: clocked state uses non-blocking assignments only, so every reader sees pre-edge values.
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ripe_q     <= '0;
         ready_en_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ripe_q     <= ripe_d;
         ready_en_q <= 1'b1;
      end
   end

   // Payload storage, written on accept with the absolute release time.
   // NOTE: the payload array is deliberately not reset; pointers and ripe bits gate every use of it.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_idx] <= '{msg: in_data_i, rel_ts: now_i + delay_i + CounterWidth'(1)};
   end

`ifdef SIMMEM_DELAY_STATS_EN
   logic [31:0] stall_q;

   // Saturating count of cycles where a ripe head is held back by the consumer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_q <= '0;
      end else if (out_valid_o && !out_ready_i && (stall_q != '1)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign occupancy_o = count;
   assign stall_cnt_o = stall_q;
`endif

endmodule

// File: rtl/simmem_delay_line.sv
// simmem_delay_line: NumChannels independent timed response lanes sharing one timestamp counter.
// Define SIMMEM_DELAY_STATS_EN to add per-lane occupancy_o and stall_cnt_o outputs.
module simmem_delay_line
   import simmem_pkg::*;
#(
   parameter int NumChannels  = 2,
   parameter int DataWidth    = 64,
   parameter int Depth        = 8,
   parameter int CounterWidth = 8
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [CounterWidth-1:0]          delay_i,
   input  logic [NumChannels-1:0]           in_valid_i,
   output logic [NumChannels-1:0]           in_ready_o,
   input  logic [NumChannels*DataWidth-1:0] in_data_i,
   output logic [NumChannels-1:0]           out_valid_o,
   input  logic [NumChannels-1:0]           out_ready_i,
   output logic [NumChannels*DataWidth-1:0] out_data_o
`ifdef SIMMEM_DELAY_STATS_EN
   ,
   output logic [NumChannels*ptr_width(Depth)-1:0] occupancy_o,
   output logic [NumChannels*32-1:0]               stall_cnt_o
`endif
);

   logic [CounterWidth-1:0] now_q;

   // Free-running timestamp shared by all lanes; wraps modulo 2^CounterWidth.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) now_q <= '0;
      else         now_q <= now_q + CounterWidth'(1);
   end

   for (genvar g = 0; g < NumChannels; g++) begin : g_lane
      simmem_delay_lane #(
         .DataWidth    (DataWidth),
         .Depth        (Depth),
         .CounterWidth (CounterWidth)
      ) u_lane (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .now_i       (now_q),
         .delay_i     (delay_i),
         .in_valid_i  (in_valid_i[g]),
         .in_ready_o  (in_ready_o[g]),
         .in_data_i   (in_data_i[g*DataWidth +: DataWidth]),
         .out_valid_o (out_valid_o[g]),
         .out_ready_i (out_ready_i[g]),
         .out_data_o  (out_data_o[g*DataWidth +: DataWidth])
`ifdef SIMMEM_DELAY_STATS_EN
         ,
         .occupancy_o (occupancy_o[g*ptr_width(Depth) +: ptr_width(Depth)]),
         .stall_cnt_o (stall_cnt_o[g*32 +: 32])
`endif
      );
   end

endmodule

// File: tb/tb_simmem_delay_line.sv
// tb_simmem_delay_line: scoreboard bench for simmem_delay_line (default parameters).
// Stimulus pushes the expected message and ripe cycle; a negedge monitor checks each release.
module tb_simmem_delay_line;

   localparam int NumCh = 2;
   localparam int DW    = 64;
   localparam int Dep   = 8;
   localparam int CW    = 8;
   localparam int PtrW  = 4;

   logic                  clk_i = 1'b0;
   logic                  rst_ni;
   logic [CW-1:0]         delay_i;
   logic [NumCh-1:0]      in_valid_i;
   logic [NumCh-1:0]      in_ready_o;
   logic [NumCh*DW-1:0]   in_data_i;
   logic [NumCh-1:0]      out_valid_o;
   logic [NumCh-1:0]      out_ready_i;
   logic [NumCh*DW-1:0]   out_data_o;
`ifdef SIMMEM_DELAY_STATS_EN
   logic [NumCh*PtrW-1:0] occupancy_o;
   logic [NumCh*32-1:0]   stall_cnt_o;
`endif

   simmem_delay_line #(
      .NumChannels  (NumCh),
      .DataWidth    (DW),
      .Depth        (Dep),
      .CounterWidth (CW)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .delay_i     (delay_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (in_data_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o)
`ifdef SIMMEM_DELAY_STATS_EN
      ,
      .occupancy_o (occupancy_o),
      .stall_cnt_o (stall_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   // Cycle index: constant between posedges, so a value sampled at negedge names that cycle.
   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] data;
      int            rdy;   // first cycle the entry is ripe
   } exp_t;

   exp_t sb [NumCh][$];
   int   last_pop [NumCh];
   bit   seen [NumCh];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: first-valid cycle of each head and data at each pop.
   always @(negedge clk_i) begin
      int   exp_cyc;
      exp_t e;
      if (rst_ni) begin
         for (int l = 0; l < NumCh; l++) begin
            if (out_valid_o[l]) begin
               if (sb[l].size() == 0) begin
                  check($sformatf("unexpected_valid_lane%0d_cyc%0d", l, cyc), 1, 0);
               end else begin
                  if (!seen[l]) begin
                     // Head-of-line: not before own ripe cycle, not before the cycle after the previous pop.
                     exp_cyc = sb[l][0].rdy;
                     if (last_pop[l] + 1 > exp_cyc) exp_cyc = last_pop[l] + 1;
                     check($sformatf("first_valid_cycle_lane%0d", l), cyc, exp_cyc);
                     seen[l] = 1'b1;
                  end
                  if (out_ready_i[l]) begin
                     e = sb[l].pop_front();
                     check($sformatf("pop_data_lane%0d", l), out_data_o[l*DW +: DW], e.data);
                     last_pop[l] = cyc;
                     seen[l]     = 1'b0;
                  end
               end
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // Offer one message; the scoreboard entry is recorded in the cycle it is accepted.
   task automatic push(input int l, input logic [DW-1:0] data, input logic [CW-1:0] d);
      int   waited;
      exp_t e;
      waited               = 0;
      delay_i              = d;
      in_valid_i[l]        = 1'b1;
      in_data_i[l*DW +: DW] = data;
      @(negedge clk_i);
      while (!in_ready_o[l] && waited < 200) begin
         waited++;
         @(negedge clk_i);
      end
      if (!in_ready_o[l]) begin
         check("push_timeout", 0, 1);
      end else begin
         e.data = data;
         e.rdy  = cyc + int'(d) + 1;
         sb[l].push_back(e);
      end
      @(posedge clk_i);
      #1;
      in_valid_i[l] = 1'b0;
   endtask

   task automatic clear_model();
      for (int l = 0; l < NumCh; l++) begin
         sb[l].delete();
         seen[l]     = 1'b0;
         last_pop[l] = -1000;
      end
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      int   drops;
      rst_ni      = 1'b0;
      delay_i     = '0;
      in_valid_i  = '0;
      in_data_i   = '0;
      out_ready_i = '1;
      clear_model();

      // Reset state.
      repeat (2) @(negedge clk_i);
      check("rst_out_valid", out_valid_o, 0);
      check("rst_out_data", out_data_o, 0);
      check("rst_in_ready", in_ready_o, 0);
      rst_ni = 1'b1;
      #1;
      check("in_ready_before_first_edge", in_ready_o, 0);
      idle(1);
      check("in_ready_after_first_edge", in_ready_o, 2'b11);
`ifdef SIMMEM_DELAY_STATS_EN
      check("occupancy_after_reset", occupancy_o, 0);
`endif

      // d=0, single push on lane 0 around cycle 10: one-cycle latency.
      while (cyc < 10) idle(1);
      push(0, 64'hA5A5_0000_0000_0031, 8'd0);
      idle(5);

      // d=5, three back-to-back pushes on lane 0; lane 1 idle.
      push(0, 64'h0000_0032_0000_0001, 8'd5);
      push(0, 64'h0000_0032_0000_0002, 8'd5);
      push(0, 64'h0000_0032_0000_0003, 8'd5);
      idle(12);

      // Head-of-line: A (d=20) then B (d=1) on lane 1; B follows A.
      push(1, 64'h0000_0035_0000_000A, 8'd20);
      push(1, 64'h0000_0035_0000_000B, 8'd1);
      idle(30);

      // Fill lane 0 with the consumer stalled.
      out_ready_i[0] = 1'b0;
      for (int i = 0; i < Dep; i++) push(0, 64'h0000_0033_0000_0000 + 64'(i), 8'd0);
      @(negedge clk_i);
      check("full_in_ready_low", in_ready_o[0], 0);
      check("full_head_valid", out_valid_o[0], 1);
      // Ninth message offered while one pop happens: full this cycle, so it must wait.
      @(posedge clk_i);
      #1;
      delay_i        = 8'd0;
      in_data_i[0 +: DW] = 64'h0000_0033_0000_0009;
      in_valid_i[0]  = 1'b1;
      out_ready_i[0] = 1'b1;
      @(negedge clk_i);
      check("full_pop_cycle_no_push", in_ready_o[0], 0);
      @(posedge clk_i);
      #1;
      out_ready_i[0] = 1'b0;
      @(negedge clk_i);
      check("ready_after_pop", in_ready_o[0], 1);
      e.data = 64'h0000_0033_0000_0009;
      e.rdy  = cyc + 1;
      sb[0].push_back(e);
      @(posedge clk_i);
      #1;
      in_valid_i[0] = 1'b0;
      @(negedge clk_i);
      check("full_again_after_ninth", in_ready_o[0], 0);
`ifdef SIMMEM_DELAY_STATS_EN
      check("occupancy_full", occupancy_o[0 +: PtrW], Dep);
`endif
      @(posedge clk_i);
      #1;
      out_ready_i[0] = 1'b1;
      idle(15);

      // Maximum delay d=255 on lane 1 and a consumer stalled long after release.
      out_ready_i[1] = 1'b0;
      push(1, 64'hFFFF_0034_0000_00FF, 8'd255);
      idle(258);
      drops = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk_i);
         if (!out_valid_o[1]) drops++;
      end
      check("sticky_ripe_drops", drops, 0);
      @(posedge clk_i);
      #1;
      out_ready_i[1] = 1'b1;
      idle(3);

      // Reset with four entries queued on lane 0.
      out_ready_i = '0;
      for (int i = 0; i < 4; i++) push(0, 64'h0000_0036_0000_0000 + 64'(i), 8'd0);
      idle(3);
      #1;
      rst_ni = 1'b0;
      clear_model();
      #1;
      check("midrst_out_valid", out_valid_o, 0);
      check("midrst_out_data", out_data_o, 0);
      check("midrst_in_ready", in_ready_o, 0);
`ifdef SIMMEM_DELAY_STATS_EN
      check("midrst_occupancy", occupancy_o, 0);
      check("midrst_stall_cnt", stall_cnt_o, 0);
`endif
      idle(2);
      @(negedge clk_i);
      rst_ni      = 1'b1;
      out_ready_i = '1;
      idle(20);
      check("post_reset_no_valid", out_valid_o, 0);
`ifdef SIMMEM_DELAY_STATS_EN
      check("post_reset_occupancy", occupancy_o, 0);
`endif
      push(0, 64'h0000_0036_0000_00EE, 8'd3);
      idle(8);

      for (int l = 0; l < NumCh; l++) check($sformatf("leftover_lane%0d", l), sb[l].size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
